// File: rtl/lcd_pixel_feeder_if.sv
// Source-side pixel stream between a frame source (pattern generator or
// SDRAM reader) and lcd_pixel_feeder.
//   data  : RGB888 pixel {R[23:16], G[15:8], B[7:0]}
//   valid : data/sof are valid this cycle
//   sof   : marks the first pixel of a frame
//   ready : sink accepts the beat (beat transfers on valid & ready)
// master = frame source, slave = feeder.
interface lcd_pixel_feeder_if #(
  parameter int DW = 24
);
  logic [DW-1:0] data;
  logic          valid;
  logic          sof;
  logic          ready;

  modport master (output data, output valid, output sof, input ready);
  modport slave  (input data, input valid, input sof, output ready);
endinterface

// File: rtl/lcd_pixel_feeder.sv
// lcd_pixel_feeder
// Buffers a streamed RGB888 image and releases one pixel per active-display
// clock in step with the LCD timing generator. Timing strobes are re-emitted
// one cycle late, aligned with the pixel data. The source stream is aligned
// to frame boundaries via sof, and every displayed frame is checked for
// pixel count and starvation.
// Ports:
//   lcd_clk, rstn           : pixel clock, synchronous active-low reset
//   in_hsync/in_vsync/in_de : raw timing from the timing generator
//   src (slave)             : source pixel stream (data/valid/sof/ready)
//   out_hsync/out_vsync/out_de/out_rgb : LCD pins, 1 cycle behind in_*
//   underflow               : pulse, pixel requested with the FIFO empty
//   frame_err               : pulse, frame check failed; resync follows
module lcd_pixel_feeder #(
  parameter int H_ACTIVE = 480,
  parameter int V_ACTIVE = 272,
  parameter int DEPTH    = 512,
  parameter int DW       = 24
) (
  input  logic                 lcd_clk,
  input  logic                 rstn,
  input  logic                 in_hsync,
  input  logic                 in_vsync,
  input  logic                 in_de,
  lcd_pixel_feeder_if.slave    src,
  output logic                 out_hsync,
  output logic                 out_vsync,
  output logic                 out_de,
  output logic [DW-1:0]        out_rgb,
  output logic                 underflow,
  output logic                 frame_err
);

  localparam int          AW        = $clog2(DEPTH);
  localparam int          CW        = AW + 1;
  localparam logic [16:0] FRAME_PIX = 17'(H_ACTIVE * V_ACTIVE);

  typedef enum logic [1:0] {ST_ALIGN, ST_PRIME, ST_RUN} state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rd_data_q;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [16:0]   pop_cnt_q, pop_cnt_d;
  logic          bad_flag_q, bad_flag_d;
  logic          vs_prev_q, vs_prev_d;
  logic          out_hsync_q, out_hsync_d;
  logic          out_vsync_q, out_vsync_d;
  logic          out_de_q, out_de_d;
  logic          rd_valid_q, rd_valid_d;
  logic          underflow_q, underflow_d;
  logic          frame_err_q, frame_err_d;

  logic accept, vs_fall, fifo_empty, frame_bad;
  logic push, pop_req, pop_ok, flush, clr_frame;

  // Ready depends only on occupancy and reset, never on src.valid.
  assign src.ready  = rstn & (count_q < CW'(DEPTH));
  assign accept     = src.valid & src.ready;
  assign vs_fall    = ~in_vsync & vs_prev_q;
  assign fifo_empty = (count_q == '0);
  assign frame_bad  = (pop_cnt_q != FRAME_PIX) | bad_flag_q;

  // FSM: state register
  always_ff @(posedge lcd_clk) begin
    if (!rstn) state_q <= ST_ALIGN;
    else       state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ALIGN: if (accept && src.sof)       state_d = ST_PRIME;
      ST_PRIME: if (vs_fall)                 state_d = ST_RUN;
      ST_RUN:   if (vs_fall && frame_bad)    state_d = ST_ALIGN;
      default:                               state_d = ST_ALIGN;
    endcase
  end

  // FSM: outputs (FIFO and frame-check controls)
  always_comb begin
    push        = 1'b0;
    pop_req     = 1'b0;
    flush       = 1'b0;
    clr_frame   = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      // Discard everything up to the first sof beat, which is kept.
      ST_ALIGN: push = accept & src.sof;
      ST_PRIME: begin
        push      = accept;
        clr_frame = vs_fall;
      end
      ST_RUN: begin
        if (vs_fall && frame_bad) begin
          // A beat accepted in the flush cycle is dropped on purpose.
          flush       = 1'b1;
          frame_err_d = 1'b1;
        end else begin
          push      = accept;
          pop_req   = in_de;
          clr_frame = vs_fall;
        end
      end
      default: ;
    endcase
  end

  // No bypass: a pop at count 0 always underflows, even with a push.
  assign pop_ok      = pop_req & ~fifo_empty;
  assign underflow_d = pop_req & fifo_empty;

  always_comb begin
    wr_ptr_d    = push   ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d    = pop_ok ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d     = count_q + CW'(push) - CW'(pop_ok);
    pop_cnt_d   = pop_req ? pop_cnt_q + 17'd1 : pop_cnt_q;
    bad_flag_d  = bad_flag_q | underflow_d;
    if (clr_frame) begin
      pop_cnt_d  = '0;
      bad_flag_d = 1'b0;
    end
    if (flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      pop_cnt_d  = '0;
      bad_flag_d = 1'b0;
    end
    vs_prev_d   = in_vsync;
    out_hsync_d = in_hsync;
    out_vsync_d = in_vsync;
    out_de_d    = in_de;
    rd_valid_d  = pop_ok;
  end

  always_ff @(posedge lcd_clk) begin
    if (!rstn) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      pop_cnt_q   <= '0;
      bad_flag_q  <= 1'b0;
      vs_prev_q   <= 1'b1;
      out_hsync_q <= 1'b1;
      out_vsync_q <= 1'b1;
      out_de_q    <= 1'b0;
      rd_valid_q  <= 1'b0;
      underflow_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      pop_cnt_q   <= pop_cnt_d;
      bad_flag_q  <= bad_flag_d;
      vs_prev_q   <= vs_prev_d;
      out_hsync_q <= out_hsync_d;
      out_vsync_q <= out_vsync_d;
      out_de_q    <= out_de_d;
      rd_valid_q  <= rd_valid_d;
      underflow_q <= underflow_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Pixel storage with registered read; kept reset-free so it maps to RAM.
  always_ff @(posedge lcd_clk) begin
    if (push)   mem[wr_ptr_q] <= src.data;
    if (pop_ok) rd_data_q     <= mem[rd_ptr_q];
  end

  assign out_hsync = out_hsync_q;
  assign out_vsync = out_vsync_q;
  assign out_de    = out_de_q;
  // Black unless a real pixel was read (blanking, underflow, align/prime).
  assign out_rgb   = rd_valid_q ? rd_data_q : '0;
  assign underflow = underflow_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_lcd_pixel_feeder.sv
module tb_lcd_pixel_feeder;
  localparam int H  = 8;
  localparam int V  = 4;
  localparam int D  = 16;
  localparam int DW = 24;
  localparam int HT = 12;   // clocks per line
  localparam int VT = 6;    // lines per frame: 0 vsync, 1 blank, 2..5 active

  logic          lcd_clk = 1'b0;
  logic          rstn = 1'b0;
  logic          in_hsync = 1'b1, in_vsync = 1'b1, in_de = 1'b0;
  logic          out_hsync, out_vsync, out_de, underflow, frame_err;
  logic [DW-1:0] out_rgb;

  lcd_pixel_feeder_if #(.DW(DW)) src_if ();

  lcd_pixel_feeder #(.H_ACTIVE(H), .V_ACTIVE(V), .DEPTH(D), .DW(DW)) dut (
    .lcd_clk   (lcd_clk),
    .rstn      (rstn),
    .in_hsync  (in_hsync),
    .in_vsync  (in_vsync),
    .in_de     (in_de),
    .src       (src_if),
    .out_hsync (out_hsync),
    .out_vsync (out_vsync),
    .out_de    (out_de),
    .out_rgb   (out_rgb),
    .underflow (underflow),
    .frame_err (frame_err)
  );

  typedef struct {
    int          frame;
    logic [23:0] rgb;
    logic        uf;
  } exp_t;

  exp_t        exp_q[$];
  int          err_q[$];
  logic [24:0] src_q[$];   // {sof, data}
  int          total = 0;
  int          bad = 0;
  int          acc_cnt = 0;
  int          fnum = 0, gl = 1, gx = 0;
  int          ofnum = 0;
  logic        prev_ov = 1'b1;

  initial forever #5 lcd_clk = ~lcd_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Timing generator, driven on the falling edge.
  initial begin
    forever begin
      @(negedge lcd_clk);
      gx++;
      if (gx == HT) begin
        gx = 0;
        gl++;
        if (gl == VT) gl = 0;
      end
      if (gx == 0 && gl == 0) fnum++;
      in_vsync = (gl != 0);
      in_hsync = !(gx == 9 || gx == 10);
      in_de    = (gl >= 2) && (gx < H);
    end
  end

  // Source driver: offers the head of src_q, retires it on acceptance.
  initial begin
    src_if.valid = 1'b0;
    src_if.sof   = 1'b0;
    src_if.data  = '0;
    forever begin
      @(posedge lcd_clk);
      if (src_if.valid && src_if.ready) begin
        void'(src_q.pop_front());
        acc_cnt++;
      end
      @(negedge lcd_clk);
      if (src_q.size() > 0) begin
        src_if.valid = 1'b1;
        {src_if.sof, src_if.data} = src_q[0];
      end else begin
        src_if.valid = 1'b0;
        src_if.sof   = 1'b0;
      end
    end
  end

  // Monitor: compares every displayed pixel against the scoreboard.
  initial begin
    forever begin
      @(negedge lcd_clk);
      if (prev_ov && !out_vsync) ofnum++;
      prev_ov = out_vsync;
      if (out_de) begin
        while (exp_q.size() > 0 && exp_q[0].frame < ofnum) begin
          total++;
          bad++;
          $display("FAIL missing_px: frame %0d rgb %06h never shown, now frame %0d",
                   exp_q[0].frame, exp_q[0].rgb, ofnum);
          void'(exp_q.pop_front());
        end
        if (exp_q.size() > 0 && exp_q[0].frame == ofnum) begin
          exp_t e;
          e = exp_q.pop_front();
          check($sformatf("pixel f%0d", ofnum), {7'b0, underflow, out_rgb}, {7'b0, e.uf, e.rgb});
        end else begin
          check("idle_px", {7'b0, underflow, out_rgb}, 32'h0);
        end
      end else begin
        check("blank_px", {7'b0, underflow, out_rgb}, 32'h0);
      end
      while (err_q.size() > 0 && err_q[0] < ofnum) begin
        total++;
        bad++;
        $display("FAIL missing_frame_err: expected in frame %0d, now frame %0d", err_q[0], ofnum);
        void'(err_q.pop_front());
      end
      if (frame_err) begin
        if (err_q.size() > 0) begin
          check("frame_err_frame", ofnum, err_q[0]);
          void'(err_q.pop_front());
        end else begin
          check("frame_err_unexpected", 32'd1, 32'd0);
        end
      end
    end
  end

  task automatic wait_src_idle();
    int n = 0;
    while (src_q.size() > 0 && n < 2000) begin
      @(posedge lcd_clk);
      n++;
    end
    check("src_drain", 32'(src_q.size()), 32'd0);
  endtask

  // Queue ndisc non-sof beats then nfr frames right after a vsync fall, so
  // the first frame is displayed in the frame after the next vsync fall.
  task automatic start_stream(input int nfr, input int ndisc, output int f0);
    int k;
    logic [23:0] d;
    wait_src_idle();
    k = fnum;
    while (fnum == k) @(posedge lcd_clk);
    f0 = fnum + 1;
    for (int i = 0; i < ndisc; i++) src_q.push_back({1'b0, 24'hDE0000 | 24'(i)});
    for (int f = 0; f < nfr; f++) begin
      for (int i = 0; i < H * V; i++) begin
        d = {8'(f0 + f), 8'(i), 8'h5A};
        src_q.push_back({(i == 0), d});
        exp_q.push_back('{f0 + f, d, 1'b0});
      end
    end
  endtask

  task automatic wait_pos(input int f, input int l, input int x);
    while (!(fnum == f && gl == l && gx == x)) @(posedge lcd_clk);
  endtask

  initial begin
    int f0, f1, f2, n;
    // Reset values
    repeat (4) @(posedge lcd_clk);
    #1;
    check("rst_out_hsync", 32'(out_hsync), 32'd1);
    check("rst_out_vsync", 32'(out_vsync), 32'd1);
    check("rst_out_de", 32'(out_de), 32'd0);
    check("rst_out_rgb", 32'(out_rgb), 32'd0);
    check("rst_underflow", 32'(underflow), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    check("rst_src_ready", 32'(src_if.ready), 32'd0);
    @(negedge lcd_clk);
    rstn = 1'b1;
    #1;
    check("ready_after_rst", 32'(src_if.ready), 32'd1);

    // 5 beats without sof are discarded, then 3 full frames; the 4th
    // frame starves (all underflow) and frame_err follows.
    start_stream(3, 5, f0);
    repeat (40) @(posedge lcd_clk);
    #1;
    check("ready_when_full", 32'(src_if.ready), 32'd0);
    check("accepted_before_run", acc_cnt, 32'd21);
    for (int i = 0; i < H * V; i++) exp_q.push_back('{f0 + 3, 24'h0, 1'b1});
    err_q.push_back(f0 + 4);
    while (fnum < f0 + 5) @(posedge lcd_clk);

    // One-cycle reset mid-line on the second displayed frame.
    start_stream(2, 0, f1);
    wait_pos(f1 + 1, 3, 4);
    @(negedge lcd_clk);
    rstn = 1'b0;
    @(posedge lcd_clk);
    #1;
    rstn = 1'b1;
    #1;
    check("midrst_out_de", 32'(out_de), 32'd0);
    check("midrst_out_rgb", 32'(out_rgb), 32'd0);
    check("midrst_src_ready", 32'(src_if.ready), 32'd1);
    n = 0;
    while (exp_q.size() > 0 && exp_q[0].frame == f1 + 1) begin
      void'(exp_q.pop_front());
      n++;
    end
    check("midrst_px_not_shown", n, 32'd19);

    // One good frame, then a push coinciding with an underflowing pop.
    start_stream(1, 0, f2);
    for (int i = 0; i < H * V; i++) begin
      if (i == 4) exp_q.push_back('{f2 + 1, 24'hC0FFEE, 1'b0});
      else        exp_q.push_back('{f2 + 1, 24'h0, 1'b1});
    end
    err_q.push_back(f2 + 2);
    wait_pos(f2 + 1, 2, 2);
    src_q.push_back({1'b0, 24'hC0FFEE});
    while (fnum < f2 + 3) @(posedge lcd_clk);
    repeat (20) @(posedge lcd_clk);

    check("exp_left", 32'(exp_q.size()), 32'd0);
    check("err_left", 32'(err_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/lcd_pixel_feeder.md
# lcd_pixel_feeder

Buffers a streamed RGB888 image from an upstream source (pattern generator or SDRAM reader) and releases one pixel per active-display clock in step with the 480x272 LCD timing generator. It sits between the frame source and the LCD output pins. It takes raw hsync/vsync/de from the timing generator and re-emits them, one cycle late, alongside the pixel data. It also aligns the source stream to frame boundaries and reports underflow and frame-length errors.

## Interface
Parameters:
- H_ACTIVE, 480, active pixels per line
- V_ACTIVE, 272, active lines per frame
- DEPTH, 512, FIFO entries; must be a power of 2
- DW, 24, pixel width {R[23:16], G[15:8], B[7:0]}

Ports:
- lcd_clk  in  1  pixel clock (9 MHz); all logic is on the rising edge
- rstn  in  1  reset: synchronous, active-low
- in_hsync  in  1  timing-generator hsync, active-low
- in_vsync  in  1  timing-generator vsync, active-low
- in_de  in  1  timing-generator data enable (hsync_de & vsync_de)
- src_data  in  DW  source pixel
- src_valid  in  1  src_data is valid
- src_sof  in  1  qualifies a beat as the first pixel of a frame
- src_ready  out  1  the feeder accepts a beat
- out_hsync  out  1  in_hsync delayed 1 cycle
- out_vsync  out  1  in_vsync delayed 1 cycle
- out_de  out  1  in_de delayed 1 cycle
- out_rgb  out  DW  pixel aligned to out_de; 0 when out_de=0
- underflow  out  1  1-cycle pulse: pop requested with the FIFO empty
- frame_err  out  1  1-cycle pulse: frame failed its check; resync follows

## Operation
- FIFO: DEPTH x DW register array with synchronous read.
  - count is clog2(DEPTH)+1 bits; pointers wrap modulo DEPTH.
- Beat acceptance: a beat is accepted when src_valid & src_ready.
  - src_ready = (count < DEPTH) while rstn=1; src_ready = 0 while rstn=0.
- Vsync edge: vs_fall is 1 when in_vsync is 0 and its previous registered value was 1 (frame start).
- State ALIGN (entered on reset):
  - Accepted beats with src_sof=0 are discarded.
  - The first accepted beat with src_sof=1 is written to the FIFO; go to PRIME.
- State PRIME:
  - Accepted beats are written to the FIFO. No pops.
  - On vs_fall: clear pop_cnt and bad_flag; go to RUN.
- State RUN:
  - Accepted beats are written to the FIFO.
  - Pop whenever in_de=1.
    - Pop with count>0: read the FIFO and increment pop_cnt (17 bits).
    - Pop with count=0: assert underflow, set bad_flag, output black, leave pointers unchanged, and still increment pop_cnt.
- Frame check in RUN on vs_fall:
  - If pop_cnt != H_ACTIVE*V_ACTIVE (130560) or bad_flag=1: pulse frame_err, flush the FIFO (count=0, pointers=0), drop any beat accepted that cycle, go to ALIGN.
  - Otherwise clear pop_cnt and bad_flag and stay in RUN.
- src_sof in PRIME or RUN is ignored for alignment; it is written as ordinary data.
- Simultaneous push and pop:
  - With count>0: count is unchanged.
  - With count=0: no bypass. The pop underflows and the push is stored.
- Full: src_ready=0 blocks the push. A pop in that cycle frees a slot from the next cycle on.

## Timing
- Latency: in_* to out_* is 1 cycle. A pixel popped at cycle t appears on out_rgb at t+1 with out_de=1.
- src_ready is combinational from count and rstn only. It never depends on src_valid.
- underflow is asserted in cycle t+1, coincident with the black pixel. frame_err is asserted the cycle after vs_fall.
- Reset values (rstn=0 sampled at an edge):
  - out_hsync=1, out_vsync=1, out_de=0, out_rgb=0
  - underflow=0, frame_err=0
  - state=ALIGN, FIFO empty, pop_cnt=0, vsync history=1
- Reset mid-frame discards all buffered pixels. Realignment requires a new src_sof.

## Test plan
- Reset, then stream a 480x272 frame with src_sof on beat 0, src_valid continuous, for 3 frames -> out_rgb matches the source order exactly, underflow=0, frame_err=0, and src_ready drops when count=512.
- Send 100 beats without sof, then sof + frame -> the first 100 are discarded and the first displayed pixel is the sof beat.
- Stall src_valid for 600 cycles mid-frame in RUN -> an underflow pulse on the first empty de cycle with out_rgb=0; frame_err at the next vs_fall; FIFO flushed; state=ALIGN.
- Source delivers a short frame (130559 beats) followed by the next sof -> pop_cnt still equals 130560 (the first next-frame pixel fills the slot), but underflow from starvation sets frame_err -> resync.
- Assert rstn=0 for 1 cycle mid-line -> the next cycle shows out_de=0, out_rgb=0, src_ready=1, and display resumes only after a sof beat and a vs_fall.
- At count=0 with in_de=1 and a simultaneous push -> underflow=1, count becomes 1, and the next pop returns that pixel.
